// File: rtl/avmm_regbank_pkg.sv
// Shared types and limits for the Avalon-MM register bank.
// Optional byte enables: define AVMM_REGBANK_BYTEEN_EN.
package avmm_regbank_pkg;

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

   localparam int WS_CNT_W = 4;
   localparam int MAX_WAIT = 15;

endpackage

// File: rtl/avmm_ws_gen.sv
// Wait-state generator: stalls each transfer for WAIT_STATES cycles.
// Asserts done in the cycle where the transfer completes.
module avmm_ws_gen
   import avmm_regbank_pkg::*;
#(
   parameter int WAIT_STATES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   output logic waitrequest,
   output logic done
);

   localparam logic [WS_CNT_W-1:0] WS = WS_CNT_W'(WAIT_STATES);

   state_t              state;
   logic [WS_CNT_W-1:0] cnt;

   assign waitrequest = req & (cnt != WS);
   assign done        = req & (cnt == WS);

   // Count stall cycles; drop back to idle on completion or abandoned request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req && (WS != '0)) begin
                  state <= WAIT;
                  cnt   <= WS_CNT_W'(1);
               end
            end
            WAIT: begin
               if (!req || (cnt == WS)) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/avmm_regbank_ws.sv
// Avalon-MM register bank with read-back, address decode and wait states.
// Optional byte enables: define AVMM_REGBANK_BYTEEN_EN.
module avmm_regbank_ws
   import avmm_regbank_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                NUM_REGS    = 4,
   parameter int                ADDR_W      = 2,
   parameter int                WAIT_STATES = 1,
   parameter logic [DATA_W-1:0] RST_VAL     = '0
) (
   input  logic                       csi_clk,
   input  logic                       rsi_reset,
   input  logic [ADDR_W-1:0]          avs_s0_address,
   input  logic                       avs_s0_write,
   input  logic [DATA_W-1:0]          avs_s0_writedata,
`ifdef AVMM_REGBANK_BYTEEN_EN
   input  logic [DATA_W/8-1:0]        avs_s0_byteenable,
`endif
   input  logic                       avs_s0_read,
   output logic [DATA_W-1:0]          avs_s0_readdata,
   output logic                       avs_s0_waitrequest,
   output logic [NUM_REGS*DATA_W-1:0] coe_s0_Dout,
   output logic [NUM_REGS-1:0]        coe_s0_update
);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              req;
   logic              done;
   logic              wr;

   assign req = avs_s0_read | avs_s0_write;
   assign wr  = avs_s0_write & done;

   avmm_ws_gen #(
      .WAIT_STATES(WAIT_STATES)
   ) u_ws (
      .clk        (csi_clk),
      .rst        (rsi_reset),
      .req        (req),
      .waitrequest(avs_s0_waitrequest),
      .done       (done)
   );

   // Commit completed writes to the addressed register and pulse its update.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
         coe_s0_update <= '0;
      end else begin
         coe_s0_update <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr && (avs_s0_address == ADDR_W'(i))) begin
`ifdef AVMM_REGBANK_BYTEEN_EN
               for (int b = 0; b < DATA_W / 8; b++) begin
                  if (avs_s0_byteenable[b])
                     regs[i][8*b +: 8] <= avs_s0_writedata[8*b +: 8];
               end
               coe_s0_update[i] <= |avs_s0_byteenable;
`else
               regs[i]          <= avs_s0_writedata;
               coe_s0_update[i] <= 1'b1;
`endif
            end
         end
      end
   end

   // Read mux: only drives data in the completion cycle of a read.
   always_comb begin
      avs_s0_readdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (avs_s0_read && done && (avs_s0_address == ADDR_W'(i)))
            avs_s0_readdata = regs[i];
      end
   end

   // Flatten the register array onto the conduit.
   always_comb begin
      coe_s0_Dout = '0;
      for (int i = 0; i < NUM_REGS; i++)
         coe_s0_Dout[i*DATA_W +: DATA_W] = regs[i];
   end

endmodule

// File: tb/tb_avmm_regbank_ws.sv
// Bench for avmm_regbank_ws: three instances (1, 3 and 0 wait states).
// Instance 0 has a 3-bit address so out-of-range decode can be exercised.
module tb_avmm_regbank_ws;

   typedef struct {
      int          waits;
      logic [31:0] rd;
      logic [3:0]  upd;
   } sb_t;

   logic         clk = 1'b0;
   logic         rst   [3];
   logic [2:0]   addr  [3];
   logic         wr    [3];
   logic         rd    [3];
   logic [31:0]  wdat  [3];
`ifdef AVMM_REGBANK_BYTEEN_EN
   logic [3:0]   be    [3];
`endif
   logic [31:0]  rdata [3];
   logic         wreq  [3];
   logic [127:0] dout  [3];
   logic [3:0]   upd   [3];

   logic [31:0]  mdl   [3][4];
   sb_t          sbq[$];
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int WS = (k == 0) ? 1 : ((k == 1) ? 3 : 0);
      localparam int AW = (k == 0) ? 3 : 2;
      avmm_regbank_ws #(
         .DATA_W     (32),
         .NUM_REGS   (4),
         .ADDR_W     (AW),
         .WAIT_STATES(WS),
         .RST_VAL    (32'h0)
      ) u_dut (
         .csi_clk           (clk),
         .rsi_reset         (rst[k]),
         .avs_s0_address    (addr[k][AW-1:0]),
         .avs_s0_write      (wr[k]),
         .avs_s0_writedata  (wdat[k]),
`ifdef AVMM_REGBANK_BYTEEN_EN
         .avs_s0_byteenable (be[k]),
`endif
         .avs_s0_read       (rd[k]),
         .avs_s0_readdata   (rdata[k]),
         .avs_s0_waitrequest(wreq[k]),
         .coe_s0_Dout       (dout[k]),
         .coe_s0_update     (upd[k])
      );
   end

   function automatic int wsv(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
   endfunction

   function automatic logic [127:0] mdout(input int k);
      return {mdl[k][3], mdl[k][2], mdl[k][1], mdl[k][0]};
   endfunction

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic xfer(input int k, input bit w, input bit r,
                       input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] b);
      sb_t        e;
      int         waits;
      bit         got;
      logic [3:0] m;
`ifdef AVMM_REGBANK_BYTEEN_EN
      m = b;
`else
      m = b | 4'hF;
`endif
      e.waits = wsv(k);
      e.rd    = (r && a < 3'd4) ? mdl[k][a[1:0]] : 32'h0;
      e.upd   = (w && a < 3'd4 && m != 4'h0) ? (4'h1 << a[1:0]) : 4'h0;
      sbq.push_back(e);
      if (w && a < 3'd4)
         for (int i = 0; i < 4; i++)
            if (m[i]) mdl[k][a[1:0]][8*i +: 8] = d[8*i +: 8];
      @(posedge clk); #1;
      addr[k] = a;
      wdat[k] = d;
      wr[k]   = w;
      rd[k]   = r;
`ifdef AVMM_REGBANK_BYTEEN_EN
      be[k]   = b;
`endif
      waits = 0;
      got   = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (wreq[k]) begin
            waits++;
            chk("stall_rdata", 128'(rdata[k]), '0);
            if (c != 39) begin
               @(posedge clk); #1;
            end
         end else begin
            got = 1'b1;
            e   = sbq.pop_front();
            chk("wait_cnt", 128'(waits), 128'(e.waits));
            if (r) chk("rdata", 128'(rdata[k]), 128'(e.rd));
         end
      end
      chk("timeout", 128'(got), 128'(1));
      @(posedge clk); #1;
      wr[k] = 1'b0;
      rd[k] = 1'b0;
      @(negedge clk);
      chk("upd_pulse", 128'(upd[k]), 128'(e.upd));
      chk("dout", dout[k], mdout(k));
      @(negedge clk);
      chk("upd_clear", 128'(upd[k]), '0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k]  = 1'b1;
         addr[k] = '0;
         wr[k]   = 1'b0;
         rd[k]   = 1'b0;
         wdat[k] = '0;
`ifdef AVMM_REGBANK_BYTEEN_EN
         be[k]   = 4'hF;
`endif
         for (int i = 0; i < 4; i++) mdl[k][i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_dout", dout[k], '0);
         chk("rst_upd", 128'(upd[k]), '0);
         chk("rst_wreq", 128'(wreq[k]), '0);
      end

      xfer(0, 1, 0, 3'd2, 32'hDEADBEEF, 4'hF);
      xfer(1, 1, 0, 3'd2, 32'hDEADBEEF, 4'hF);
      xfer(1, 0, 1, 3'd2, 32'h0, 4'hF);
      xfer(0, 0, 1, 3'd2, 32'h0, 4'hF);
      xfer(0, 1, 0, 3'd5, 32'h99, 4'hF);
      xfer(0, 0, 1, 3'd6, 32'h0, 4'hF);
      xfer(0, 1, 1, 3'd2, 32'hCAFEF00D, 4'hF);
      xfer(0, 1, 0, 3'd3, 32'h0BAD_F00D, 4'hF);

      @(posedge clk); #1;
      wr[2] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr[2] = 3'(i);
         wdat[2] = 32'(8'h11 * (i + 1));
         mdl[2][i] = wdat[2];
         @(negedge clk);
         chk("burst_wreq", 128'(wreq[2]), '0);
         if (i > 0) chk("burst_upd", 128'(upd[2]), 128'(4'h1 << (i - 1)));
         @(posedge clk); #1;
      end
      wr[2] = 1'b0;
      @(negedge clk);
      chk("burst_upd", 128'(upd[2]), 128'(4'h8));
      chk("burst_dout", dout[2], mdout(2));

      @(posedge clk); #1;
      addr[1] = 3'd3;
      wdat[1] = 32'h77;
      wr[1]   = 1'b1;
      @(negedge clk);
      chk("drop_wreq", 128'(wreq[1]), 128'(1));
      @(posedge clk); #1;
      wr[1] = 1'b0;
      @(negedge clk);
      chk("drop_upd", 128'(upd[1]), '0);
      chk("drop_dout", dout[1], mdout(1));
      xfer(1, 0, 1, 3'd3, 32'h0, 4'hF);

      @(posedge clk); #1;
      addr[1] = 3'd1;
      wdat[1] = 32'h55;
      wr[1]   = 1'b1;
      @(posedge clk); #2;
      rst[1] = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) mdl[1][i] = '0;
      chk("arst_dout", dout[1], '0);
      chk("arst_wreq", 128'(wreq[1]), 128'(1));
      wr[1] = 1'b0;
      #1;
      rst[1] = 1'b0;
      @(negedge clk);
      chk("arst_upd", 128'(upd[1]), '0);
      xfer(1, 1, 0, 3'd1, 32'h1234, 4'hF);

`ifdef AVMM_REGBANK_BYTEEN_EN
      xfer(0, 1, 0, 3'd0, 32'hAABBCCDD, 4'hF);
      xfer(0, 1, 0, 3'd0, 32'h11223344, 4'b0101);
      chk("be_mix", 128'(dout[0][31:0]), 128'(32'hAA22CC44));
      xfer(0, 1, 0, 3'd0, 32'hFFFFFFFF, 4'b0000);
      chk("be_none", 128'(dout[0][31:0]), 128'(32'hAA22CC44));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
